tone_period_decoder: RTL and testbench
======================================

// Module: tone_period_decoder
// PURPOSE
//  Receive side of the speaker tone path: samples a square-wave tone (PWM music line, 50% duty), measures its period and
//  decodes it back to the 6-bit note index used by the key encoder/record path (0 = none, 1..48 = C3..B6).
//  Sits beside the player controller for loopback self-check and for note capture from an external tone source.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency; sets the period table
//  PERIOD_W    24           period counter width; counter saturates at all-ones
//  TIMEOUT_CYC 2_000_000    cycles without a rising edge before the decoder declares silence (20 ms)
//  TOL_SHIFT   6            match tolerance = table_period >> TOL_SHIFT (about 1.56%)
//  STABLE_CNT  3            consecutive identical matches required; used only with NOTE_STABLE_EN
// PORTS
//  clk            in   1         system clock
//  reset          in   1         synchronous, active-low reset
//  enable         in   1         0 = decoder idle and outputs cleared
//  pwm_in         in   1         asynchronous tone input
//  period         out  PERIOD_W  last measured rising-to-rising period, in clk cycles
//  period_strobe  out  1         1-cycle pulse when period updates
//  note_idx       out  6         decoded note, 0 when none or unmatched
//  note_valid     out  1         note_idx holds a matched note
//  silent         out  1         no edge within TIMEOUT_CYC, or enable = 0
// BEHAVIOUR
//  - Reset (reset = 0 at clk edge): state = S_IDLE, period = 0, period_strobe = 0, note_idx = 0, note_valid = 0, silent = 1.
//  - pwm_in passes through a 2-FF synchronizer. A rising edge is detected from the synchronized value and its delay (2-3 cycles of input latency).
//  - FSM states:
//    - S_IDLE: entered when enable = 0, from any state, in the next cycle. Outputs are cleared as on reset.
//    - S_ARM: the first rising edge clears the counter and moves to S_MEAS. No period is produced from this edge.
//    - S_MEAS: the counter increments every cycle. On a rising edge: period <= count + 1, period_strobe = 1, the counter restarts at 0, and the FSM moves to S_MATCH.
//    - S_MATCH: scans table entries i = 1..48 at one per cycle, so it takes 48 cycles. A match is |period - T[i]| <= T[i] >> TOL_SHIFT, and the lowest matching i wins. The next cycle updates note_idx/note_valid (matched: i and 1; unmatched: 0 and 0), clears silent, and returns to S_MEAS. Latency from period_strobe to note update is 49 cycles.
//  - Edges during S_MATCH still restart the counter. They produce no strobe and no new match; measurement resumes normally. Real tone periods are far above 49 cycles.
//  - Timeout: the counter reaches TIMEOUT_CYC in S_MEAS, or in S_ARM (counted while armed). Result: note_idx = 0, note_valid = 0, silent = 1, period unchanged, FSM goes to S_ARM.
//  - The counter saturates at 2^PERIOD_W - 1 and never wraps.
//  - The difference uses PERIOD_W+1-bit signed arithmetic; the tolerance is a truncating shift.
//  - Reset or enable dropping mid-S_MATCH aborts the scan; no partial result is written.
// CONFIGURATION
//  NOTE_STABLE_EN defined:
//    - A match result is committed only after STABLE_CNT consecutive S_MATCH results give the same index (matched or 0).
//    - A differing result restarts the run at 1. Timeout and silence still clear outputs immediately.
//  NOTE_STABLE_EN undefined: every S_MATCH result is committed directly, as described above.
// STRUCTURE
//  Package tone_pkg holds:
//    - NOTE_NUM = 48 and NOTE_W = 6.
//    - The state encoding (S_IDLE, S_ARM, S_MEAS, S_MATCH).
//    - A function note_period(i, CLK_HZ) giving round(CLK_HZ / f_i), where f_i = 130.81 Hz * 2^((i-1)/12).
//  Sub-module tone_period_table: combinational ROM mapping index (6 bits) to period (PERIOD_W bits), built from tone_pkg.
//  Top level: synchronizer, edge detector, counter, FSM, match comparator, commit/stability logic.
// TESTING
//  1. Reset held 5 cycles, then enable = 1 with no input -> note_idx = 0, note_valid = 0, silent = 1, period = 0.
//  2. 440 Hz square wave (period 227273 cycles) -> after the 2nd rising edge, period = 227273 with a strobe; 49 cycles later note_idx = 22, note_valid = 1, silent = 0.
//  3. Period 234000 (between G#4 = 240790 and A4) -> period_strobe fires; note_idx = 0, note_valid = 0, silent = 0.
//  4. Input held low after tone 22 -> exactly TIMEOUT_CYC cycles after the last edge: silent = 1, note_idx = 0; a new tone re-arms (first edge gives no strobe).
//  5. Reset and, separately, enable = 0 asserted mid-S_MATCH -> outputs cleared next cycle, no note update; the next full period decodes correctly.
//  6. NOTE_STABLE_EN, STABLE_CNT = 3: switch 22 to 23 -> note_idx changes only after the 3rd matched period of 23; with the macro undefined, after the 1st.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared definitions for the tone period decoder: note count, FSM encoding and
// the note-to-period function used to build the period ROM.
package tone_pkg;

    localparam int NOTE_NUM = 48;
    localparam int NOTE_W   = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_MEAS  = 2'd2,
        S_MATCH = 2'd3
    } state_t;

    // 2^(k/12) scaled by 1e6, so the period table is built with integer math only
    function automatic longint semitone_ratio(input int k);
        case (k)
            0:       return 64'sd1000000;
            1:       return 64'sd1059463;
            2:       return 64'sd1122462;
            3:       return 64'sd1189207;
            4:       return 64'sd1259921;
            5:       return 64'sd1334840;
            6:       return 64'sd1414214;
            7:       return 64'sd1498307;
            8:       return 64'sd1587401;
            9:       return 64'sd1681793;
            10:      return 64'sd1781797;
            11:      return 64'sd1887749;
            default: return 64'sd1000000;
        endcase
    endfunction

    // round(clk_hz / f_i), f_i = 130.81 Hz * 2^((i-1)/12); indices outside 1..48 give 0
    function automatic longint note_period(input int i, input longint clk_hz);
        longint den;
        int     oct;
        int     semi;
        if (i < 1 || i > NOTE_NUM) begin
            return 64'sd0;
        end
        oct  = (i - 1) / 12;
        semi = (i - 1) % 12;
        den  = 64'sd13081 * (64'sd1 <<< oct) * semitone_ratio(semi);
        return (clk_hz * 64'sd100_000_000 + den / 2) / den;
    endfunction

endpackage

// File: rtl/tone_period_table.sv
// Combinational ROM: note index (0..63) to nominal tone period in clock cycles.
// Entries outside 1..48 read as zero.
module tone_period_table
    import tone_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int PERIOD_W = 24
) (
    input  logic [NOTE_W-1:0]   i_idx,
    output logic [PERIOD_W-1:0] o_period
);

    localparam int     ROM_DEPTH = 1 << NOTE_W;
    localparam longint PMAX      = (64'sd1 <<< PERIOD_W) - 64'sd1;

    logic [PERIOD_W-1:0] w_rom [0:ROM_DEPTH-1];

    // Every entry is an elaboration-time constant; oversize periods clamp to the counter range
    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        localparam longint P = note_period(g, longint'(CLK_HZ));
        assign w_rom[g] = PERIOD_W'((P > PMAX) ? PMAX : P);
    end

    assign o_period = w_rom[i_idx];

endmodule

// File: rtl/tone_period_decoder.sv
// Measures the period of a 50% square tone and decodes it to a 6-bit note index.
// Optional feature: define NOTE_STABLE_EN to commit a note only after STABLE_CNT identical results.
module tone_period_decoder
    import tone_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int PERIOD_W    = 24,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int TOL_SHIFT   = 6,
    parameter int STABLE_CNT  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pwm_in,
    output logic [PERIOD_W-1:0] period,
    output logic                period_strobe,
    output logic [NOTE_W-1:0]   note_idx,
    output logic                note_valid,
    output logic                silent
);

    localparam logic [PERIOD_W-1:0] CNT_MAX      = '1;
    localparam logic [PERIOD_W-1:0] TIMEOUT_LAST = PERIOD_W'(TIMEOUT_CYC - 1);
    localparam logic [NOTE_W-1:0]   FIRST_IDX    = NOTE_W'(1);
    localparam logic [NOTE_W-1:0]   COMMIT_IDX   = NOTE_W'(NOTE_NUM + 1);
    localparam int                  RUN_W        = $clog2(STABLE_CNT + 1);
    localparam logic [RUN_W-1:0]    RUN_MAX      = RUN_W'(STABLE_CNT);
`ifdef NOTE_STABLE_EN
    localparam logic [RUN_W-1:0]    RUN_COMMIT   = RUN_W'(STABLE_CNT);
`else
    localparam logic [RUN_W-1:0]    RUN_COMMIT   = RUN_W'(1);
`endif

    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    state_t              r_state;
    logic [PERIOD_W-1:0] r_count;
    logic [NOTE_W-1:0]   r_scan_idx;
    logic                r_found;
    logic [NOTE_W-1:0]   r_found_idx;
    logic [NOTE_W-1:0]   r_cand;
    logic [RUN_W-1:0]    r_run;

    logic                w_rise;
    logic [PERIOD_W-1:0] w_cnt_inc;
    logic                w_timeout;
    logic [PERIOD_W-1:0] w_tbl;
    logic [PERIOD_W-1:0] w_tol;
    logic signed [PERIOD_W:0] w_diff;
    logic [PERIOD_W:0]   w_abs;
    logic                w_hit;
    logic [NOTE_W-1:0]   w_result;
    logic [RUN_W-1:0]    w_run_next;
    logic                w_commit;

    // Two flops bring pwm_in into the clock domain, the third gives the edge reference
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise    = r_sync2 & ~r_sync3;
    assign w_cnt_inc = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
    assign w_timeout = (r_count >= TIMEOUT_LAST);

    tone_period_table #(
        .CLK_HZ   (CLK_HZ),
        .PERIOD_W (PERIOD_W)
    ) u_table (
        .i_idx    (r_scan_idx),
        .o_period (w_tbl)
    );

    assign w_tol  = w_tbl >> TOL_SHIFT;
    assign w_diff = $signed({1'b0, period}) - $signed({1'b0, w_tbl});
    assign w_abs  = w_diff[PERIOD_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_hit  = (w_abs <= {1'b0, w_tol});

    // Run length of identical scan results; with RUN_COMMIT = 1 every result commits
    assign w_result   = r_found ? r_found_idx : '0;
    assign w_run_next = ((w_result == r_cand) && (r_run != '0))
                        ? ((r_run == RUN_MAX) ? r_run : r_run + 1'b1)
                        : RUN_W'(1);
    assign w_commit   = (w_run_next >= RUN_COMMIT);

    // Disable behaves exactly like reset so a dropped enable also aborts a scan in flight
    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_scan_idx    <= '0;
            r_found       <= 1'b0;
            r_found_idx   <= '0;
            r_cand        <= '0;
            r_run         <= '0;
            period        <= '0;
            period_strobe <= 1'b0;
            note_idx      <= '0;
            note_valid    <= 1'b0;
            silent        <= 1'b1;
        end else begin
            period_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    r_state <= S_ARM;
                end
                S_ARM: begin
                    if (w_rise) begin
                        r_count <= '0;
                        r_state <= S_MEAS;
                    end else if (w_timeout) begin
                        r_count    <= '0;
                        r_run      <= '0;
                        note_idx   <= '0;
                        note_valid <= 1'b0;
                        silent     <= 1'b1;
                    end else begin
                        r_count <= w_cnt_inc;
                    end
                end
                S_MEAS: begin
                    if (w_rise) begin
                        period        <= w_cnt_inc;
                        period_strobe <= 1'b1;
                        r_count       <= '0;
                        r_scan_idx    <= FIRST_IDX;
                        r_found       <= 1'b0;
                        r_found_idx   <= '0;
                        r_state       <= S_MATCH;
                    end else if (w_timeout) begin
                        r_count    <= '0;
                        r_run      <= '0;
                        note_idx   <= '0;
                        note_valid <= 1'b0;
                        silent     <= 1'b1;
                        r_state    <= S_ARM;
                    end else begin
                        r_count <= w_cnt_inc;
                    end
                end
                S_MATCH: begin
                    r_count <= w_rise ? '0 : w_cnt_inc;
                    // One table entry per cycle; the extra cycle at COMMIT_IDX writes the result
                    if (r_scan_idx == COMMIT_IDX) begin
                        silent  <= 1'b0;
                        r_cand  <= w_result;
                        r_run   <= w_run_next;
                        if (w_commit) begin
                            note_idx   <= w_result;
                            note_valid <= r_found;
                        end
                        r_state <= S_MEAS;
                    end else begin
                        if (w_hit && !r_found) begin
                            r_found     <= 1'b1;
                            r_found_idx <= r_scan_idx;
                        end
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_period_decoder.sv
// Directed self-checking bench for tone_period_decoder, scaled to a 500 kHz clock.
// Expectations follow NOTE_STABLE_EN when the macro is defined for the build.
module tb_tone_period_decoder;

    localparam int CLK_HZ      = 500_000;
    localparam int PERIOD_W    = 24;
    localparam int TIMEOUT_CYC = 3000;
    localparam int TOL_SHIFT   = 6;
    localparam int STABLE_CNT  = 3;
`ifdef NOTE_STABLE_EN
    localparam int RUN_TB = 3;
`else
    localparam int RUN_TB = 1;
`endif

    // Nominal periods at 500 kHz: A4 = 1136, A#4 = 1073, G#4 = 1204; 1170 sits between A4 and G#4
    localparam int P_A4  = 1136;
    localparam int P_AS4 = 1073;
    localparam int P_GS4 = 1204;
    localparam int P_GAP = 1170;

    typedef struct {
        int periodCyc;
        int edges;
        int expNote;
        int expValid;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic                pwm_in = 1'b0;
    logic [PERIOD_W-1:0] period;
    logic                period_strobe;
    logic [5:0]          note_idx;
    logic                note_valid;
    logic                silent;

    int assertCnt = 0;
    int failCnt = 0;
    int cyc = 0;
    int strobeCnt = 0;
    int lastStrobeCyc = 0;
    int lastLatency = -1;
    int silentRiseCyc = 0;
    int lastRiseCyc = 0;
    int prevNote = 0;
    bit prevValid = 1'b0;
    bit prevSilent = 1'b1;

    vec_t vecs[5];

    tone_period_decoder #(
        .CLK_HZ      (CLK_HZ),
        .PERIOD_W    (PERIOD_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TOL_SHIFT   (TOL_SHIFT),
        .STABLE_CNT  (STABLE_CNT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pwm_in        (pwm_in),
        .period        (period),
        .period_strobe (period_strobe),
        .note_idx      (note_idx),
        .note_valid    (note_valid),
        .silent        (silent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge: strobes, note commits and silence onset
    always @(negedge clk) begin
        if (period_strobe) begin
            strobeCnt++;
            lastStrobeCyc = cyc;
        end
        if (!silent && ((int'(note_idx) != prevNote) || (note_valid != prevValid))) begin
            lastLatency = cyc - lastStrobeCyc;
        end
        if (silent && !prevSilent) begin
            silentRiseCyc = cyc;
        end
        prevNote   = int'(note_idx);
        prevValid  = note_valid;
        prevSilent = silent;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCnt++;
        if (actual != expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic driveFor(input bit v, input int n);
        pwm_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Emits the given number of rising edges, each followed by one full period of the tone
    task automatic applyStimulus(input int p, input int edges);
        for (int e = 0; e < edges; e++) begin
            lastRiseCyc = cyc;
            driveFor(1'b1, p / 2);
            driveFor(1'b0, p - p / 2);
        end
    endtask

    task automatic checkCleared(input string tag);
        @(negedge clk);
        checkOutput({tag, "_note"},   int'(note_idx),   0);
        checkOutput({tag, "_valid"},  int'(note_valid), 0);
        checkOutput({tag, "_silent"}, int'(silent),     1);
        checkOutput({tag, "_period"}, int'(period),     0);
    endtask

    task automatic checkNote(input string tag, input int p, input int expNote, input int expValid);
        checkOutput({tag, "_period"}, int'(period),     p);
        checkOutput({tag, "_note"},   int'(note_idx),   expNote);
        checkOutput({tag, "_valid"},  int'(note_valid), expValid);
        checkOutput({tag, "_silent"}, int'(silent),     0);
    endtask

    // Aborts a scan about 10 cycles after the strobe, by reset or by dropping enable
    task automatic abortMidMatch(input bit useReset, input string tag);
        bit seen;
        seen = 1'b0;
        pwm_in = 1'b1;
        lastRiseCyc = cyc;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (period_strobe) seen = 1'b1;
        end
        checkOutput({tag, "_strobe"}, int'(seen), 1);
        repeat (10) @(posedge clk);
        #1;
        if (useReset) reset = 1'b0;
        else enable = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b1;
        checkCleared(tag);
        repeat (60) @(negedge clk);
        checkOutput({tag, "_noPartialNote"},   int'(note_idx), 0);
        checkOutput({tag, "_noPartialSilent"}, int'(silent),   1);
        @(posedge clk);
        #1;
        driveFor(1'b1, 400);
        driveFor(1'b0, 700);
        applyStimulus(P_A4, 4);
        checkNote({tag, "_recover"}, P_A4, 22, 1);
    endtask

    initial begin
        int s;
        vecs[0] = '{periodCyc: P_A4,  edges: 4, expNote: 22, expValid: 1};
        vecs[1] = '{periodCyc: P_GAP, edges: 4, expNote: 0,  expValid: 0};
        vecs[2] = '{periodCyc: P_AS4, edges: 4, expNote: 23, expValid: 1};
        vecs[3] = '{periodCyc: P_GS4, edges: 4, expNote: 21, expValid: 1};
        vecs[4] = '{periodCyc: P_A4,  edges: 4, expNote: 22, expValid: 1};

        $display("[TB] reset and idle input");
        reset  = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkCleared("reset");
        checkOutput("reset_strobe", int'(period_strobe), 0);

        $display("[TB] table-driven tone vectors");
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].periodCyc, vecs[v].edges);
            checkNote($sformatf("vec%0d", v), vecs[v].periodCyc, vecs[v].expNote, vecs[v].expValid);
            if (v == 0) checkOutput("vec0_strobeCount", strobeCnt, 3);
        end
        checkOutput("noteLatency", lastLatency, 49);

        $display("[TB] note switch 22 -> 23");
        applyStimulus(P_AS4, 1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(P_AS4, 1);
            checkOutput($sformatf("switch%0d_note", k), int'(note_idx), (k >= RUN_TB) ? 23 : 22);
        end

        $display("[TB] silence timeout and re-arm");
        driveFor(1'b0, TIMEOUT_CYC + 100);
        checkOutput("timeout_cycles", silentRiseCyc - lastRiseCyc, TIMEOUT_CYC + 3);
        checkOutput("timeout_silent", int'(silent), 1);
        checkOutput("timeout_note",   int'(note_idx), 0);
        checkOutput("timeout_valid",  int'(note_valid), 0);
        checkOutput("timeout_period", int'(period), P_AS4);
        s = strobeCnt;
        applyStimulus(P_A4, 1);
        checkOutput("rearm_noStrobe", strobeCnt - s, 0);
        applyStimulus(P_A4, 3);
        checkNote("rearm", P_A4, 22, 1);

        $display("[TB] abort during match scan");
        abortMidMatch(1'b1, "abortReset");
        abortMidMatch(1'b0, "abortEnable");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
